computie_bus_snooper_control: RTL and testbench

- Command sequencer for computie_bus_snooper, clocked on comm_clock.
- Accepts single-byte commands from the host link (UART RX byte stream) and drives the snooper's record/trigger/dump controls.
- Frames the snooper's dump byte stream with a header and byte-count trailer onto the host TX byte stream.
- Answers status queries.

---
 rtl/computie_bus_snooper_control_if.sv | 32 +++
 rtl/computie_bus_snooper_control.sv | 165 ++++++++++++++++
 tb/tb_computie_bus_snooper_control.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/computie_bus_snooper_control_if.sv
// Host command/TX byte streams plus the snooper control and dump stream.
// master = the command sequencer, slave = host link and snooper side.
interface computie_bus_snooper_control_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       record_start;
    logic       record_end;
    logic       record_trigger;
    logic       dump_start;
    logic       dump_end;
    logic       snoop_valid;
    logic       snoop_ready;
    logic [7:0] snoop_data;
    logic       busy;
    logic       timed_out;

    modport master (
        input  cmd_valid, cmd_data, tx_ready, record_end, dump_end, snoop_valid, snoop_data,
        output cmd_ready, tx_valid, tx_data, record_start, record_trigger, dump_start,
               snoop_ready, busy, timed_out
    );

    modport slave (
        output cmd_valid, cmd_data, tx_ready, record_end, dump_end, snoop_valid, snoop_data,
        input  cmd_ready, tx_valid, tx_data, record_start, record_trigger, dump_start,
               snoop_ready, busy, timed_out
    );
endinterface

// File: rtl/computie_bus_snooper_control.sv
// Command sequencer for the bus snooper: arms/triggers capture, frames the
// dump stream with a header and byte-count trailer, and answers status queries.
module computie_bus_snooper_control #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMER_WIDTH    = 24
) (
    input  logic                           comm_clock,
    input  logic                           reset,
    computie_bus_snooper_control_if.master bus
);
    localparam logic [7:0] CMD_ARM     = 8'h52;
    localparam logic [7:0] CMD_TRIGGER = 8'h54;
    localparam logic [7:0] CMD_DUMP    = 8'h44;
    localparam logic [7:0] CMD_STATUS  = 8'h53;
    localparam logic [7:0] CMD_ABORT   = 8'h58;

    localparam bit                     TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
        TIMER_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, RECORD, WAIT_END, HDR, DUMP, TRL0, TRL1, STAT, ERR
    } state_t;

    state_t                 state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [15:0]            byte_count;
    logic                   capture_valid;
    logic                   timed_out_q;
    logic                   record_start_q;
    logic                   record_trigger_q;
    logic                   dump_start_q;
    logic                   tx_valid_q;
    logic [7:0]             tx_data_q;

    logic cmd_fire;
    logic tx_fire;
    logic timeout_hit;

    assign cmd_fire    = bus.cmd_valid && bus.cmd_ready;
    assign tx_fire     = tx_valid_q && bus.tx_ready;
    assign timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST);

    assign bus.cmd_ready      = (state == IDLE) || (state == RECORD) || (state == WAIT_END);
    assign bus.busy           = (state != IDLE);
    assign bus.record_start   = record_start_q;
    assign bus.record_trigger = record_trigger_q;
    assign bus.dump_start     = dump_start_q;
    assign bus.timed_out      = timed_out_q;

    // During DUMP the snooper stream passes straight through to the host link.
    assign bus.tx_valid    = (state == DUMP) ? bus.snoop_valid : tx_valid_q;
    assign bus.tx_data     = (state == DUMP) ? bus.snoop_data  : tx_data_q;
    assign bus.snoop_ready = (state == DUMP) && bus.tx_ready;

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            state            <= IDLE;
            timer            <= '0;
            byte_count       <= '0;
            capture_valid    <= 1'b0;
            timed_out_q      <= 1'b0;
            record_start_q   <= 1'b0;
            record_trigger_q <= 1'b0;
            dump_start_q     <= 1'b0;
            tx_valid_q       <= 1'b0;
            tx_data_q        <= '0;
        end else begin
            record_trigger_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        case (bus.cmd_data)
                            CMD_ARM: begin
                                state          <= RECORD;
                                record_start_q <= 1'b1;
                                capture_valid  <= 1'b0;
                                timed_out_q    <= 1'b0;
                                timer          <= '0;
                            end
                            CMD_DUMP: begin
                                state      <= capture_valid ? HDR : ERR;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= capture_valid ? 8'hA5 : 8'hEE;
                            end
                            CMD_STATUS: begin
                                state      <= STAT;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= {4'h5, capture_valid, timed_out_q, 2'b00};
                            end
                            default: ;
                        endcase
                    end
                end
                RECORD: begin
                    timer <= timer + 1'b1;
                    // A finished capture beats any trigger arriving in the same cycle.
                    if (bus.record_end) begin
                        state          <= IDLE;
                        record_start_q <= 1'b0;
                        capture_valid  <= 1'b1;
                    end else if (cmd_fire && bus.cmd_data == CMD_ABORT) begin
                        state          <= IDLE;
                        record_start_q <= 1'b0;
                    end else if ((cmd_fire && bus.cmd_data == CMD_TRIGGER) || timeout_hit) begin
                        state            <= WAIT_END;
                        record_trigger_q <= 1'b1;
                        if (timeout_hit) begin
                            timed_out_q <= 1'b1;
                        end
                    end
                end
                WAIT_END: begin
                    if (bus.record_end) begin
                        state          <= IDLE;
                        record_start_q <= 1'b0;
                        capture_valid  <= 1'b1;
                    end else if (cmd_fire && bus.cmd_data == CMD_ABORT) begin
                        state          <= IDLE;
                        record_start_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (tx_fire) begin
                        state        <= DUMP;
                        byte_count   <= '0;
                        tx_valid_q   <= 1'b0;
                        dump_start_q <= 1'b1;
                    end
                end
                DUMP: begin
                    if (bus.snoop_valid && bus.tx_ready) begin
                        byte_count <= byte_count + 16'd1;
                    end
                    if (bus.dump_end && !bus.snoop_valid) begin
                        state        <= TRL0;
                        dump_start_q <= 1'b0;
                        tx_valid_q   <= 1'b1;
                        tx_data_q    <= byte_count[7:0];
                    end
                end
                TRL0: begin
                    if (tx_fire) begin
                        state     <= TRL1;
                        tx_data_q <= byte_count[15:8];
                    end
                end
                TRL1: begin
                    if (tx_fire) begin
                        state         <= IDLE;
                        tx_valid_q    <= 1'b0;
                        capture_valid <= 1'b0;
                    end
                end
                STAT, ERR: begin
                    if (tx_fire) begin
                        state      <= IDLE;
                        tx_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_computie_bus_snooper_control.sv
// Self-checking bench: expected host TX bytes go into a scoreboard queue as
// commands are issued and are popped by a monitor on every TX handshake.
module tb_computie_bus_snooper_control;
    logic comm_clock = 1'b0;
    logic reset      = 1'b1;

    always #5 comm_clock = ~comm_clock;

    computie_bus_snooper_control_if a_if ();
    computie_bus_snooper_control_if b_if ();

    computie_bus_snooper_control dut_a (
        .comm_clock (comm_clock),
        .reset      (reset),
        .bus        (a_if.master)
    );

    computie_bus_snooper_control #(.TIMEOUT_CYCLES(16), .TIMER_WIDTH(24)) dut_b (
        .comm_clock (comm_clock),
        .reset      (reset),
        .bus        (b_if.master)
    );

    typedef struct {
        logic [7:0] cmd;
        bit         has_tx;
        logic [7:0] tx;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    bit         toggle_ready = 1'b0;
    logic [7:0] snoop_bytes[40];
    int         snoop_idx = 0;
    int         trig_a = 0;
    bit         dump_seen = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    bit         took = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge comm_clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] c);
        int tries;
        tries = 0;
        a_if.cmd_valid = 1'b1;
        a_if.cmd_data  = c;
        @(negedge comm_clock);
        while (!a_if.cmd_ready && tries < 100) begin
            @(negedge comm_clock);
            tries++;
        end
        if (!a_if.cmd_ready) begin
            check_output("cmd_accept", 32'(a_if.cmd_ready), 32'd1);
        end
        @(posedge comm_clock);
        #1;
        a_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int tries;
        tries = 0;
        while (exp_q.size() != 0 && tries < budget) begin
            step(1);
            tries++;
        end
        check_output("tx_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // TX monitor: scoreboard compare on handshakes and hold-while-stalled check.
    always @(negedge comm_clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("tx_hold", {23'd0, a_if.tx_valid, a_if.tx_data}, {23'd0, 1'b1, prev_data});
            end
            if (a_if.tx_valid && a_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_tx: got %0h, expected no byte", a_if.tx_data);
                end else begin
                    check_output("tx_byte", 32'(a_if.tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = a_if.tx_valid && !a_if.tx_ready;
            prev_data  = a_if.tx_data;
            if (a_if.record_trigger) trig_a++;
            if (a_if.dump_start) dump_seen = 1'b1;
        end
    end

    // Host TX ready: always ready, or toggling every cycle during the dump test.
    initial begin
        a_if.tx_ready = 1'b1;
        forever begin
            @(posedge comm_clock);
            #1;
            a_if.tx_ready = toggle_ready ? ~a_if.tx_ready : 1'b1;
        end
    end

    // Snooper model: holds each byte until taken, then raises dump_end.
    initial begin
        a_if.snoop_valid = 1'b0;
        a_if.snoop_data  = '0;
        a_if.dump_end    = 1'b0;
        forever begin
            @(negedge comm_clock);
            took = a_if.snoop_valid && a_if.snoop_ready;
            @(posedge comm_clock);
            #1;
            if (took) snoop_idx++;
            a_if.snoop_valid = a_if.dump_start && (snoop_idx < 40);
            a_if.snoop_data  = (snoop_idx < 40) ? snoop_bytes[snoop_idx] : 8'h00;
            a_if.dump_end    = a_if.dump_start && (snoop_idx >= 40);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   trig_cnt;
        int   trig_cyc;
        int   trig_before;
        int   tries;

        vecs[0] = '{8'h53, 1'b1, 8'h50};
        vecs[1] = '{8'h54, 1'b0, 8'h00};
        vecs[2] = '{8'h44, 1'b1, 8'hEE};
        vecs[3] = '{8'h00, 1'b0, 8'h00};
        vecs[4] = '{8'h58, 1'b0, 8'h00};
        vecs[5] = '{8'hFF, 1'b0, 8'h00};
        vecs[6] = '{8'h53, 1'b1, 8'h50};

        a_if.cmd_valid   = 1'b0;
        a_if.cmd_data    = '0;
        a_if.record_end  = 1'b0;
        b_if.cmd_valid   = 1'b0;
        b_if.cmd_data    = '0;
        b_if.tx_ready    = 1'b1;
        b_if.record_end  = 1'b0;
        b_if.dump_end    = 1'b0;
        b_if.snoop_valid = 1'b0;
        b_if.snoop_data  = '0;

        reset = 1'b1;
        step(3);
        reset = 1'b0;
        check_output("reset_outputs",
            {24'd0, a_if.cmd_ready, a_if.tx_valid, a_if.record_start, a_if.record_trigger,
             a_if.dump_start, a_if.snoop_ready, a_if.busy, a_if.timed_out},
            32'h80);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].has_tx) exp_q.push_back(vecs[i].tx);
            apply_stimulus(vecs[i].cmd);
            wait_drain(20);
            step(1);
            check_output("vec_idle", 32'(a_if.busy), 32'd0);
        end
        check_output("no_dump_start", 32'(dump_seen), 32'd0);
        check_output("idle_T_no_trig", 32'(trig_a), 32'd0);

        // Manual trigger, then capture completes 30 cycles later.
        apply_stimulus(8'h52);
        check_output("rec_start_after_R", {30'd0, a_if.record_start, a_if.busy}, 32'h3);
        step(20);
        apply_stimulus(8'h54);
        step(3);
        check_output("trig_pulse", 32'(trig_a), 32'd1);
        step(27);
        check_output("trig_single", 32'(trig_a), 32'd1);
        check_output("wait_end_rec", 32'(a_if.record_start), 32'd1);
        a_if.record_end = 1'b1;
        step(1);
        a_if.record_end = 1'b0;
        check_output("rec_start_drop", {30'd0, a_if.record_start, a_if.busy}, 32'h0);
        exp_q.push_back(8'h58);
        apply_stimulus(8'h53);
        wait_drain(20);

        // Timeout-triggered capture on the short-timeout instance.
        b_if.cmd_valid = 1'b1;
        b_if.cmd_data  = 8'h52;
        step(1);
        b_if.cmd_valid = 1'b0;
        trig_cnt = 0;
        trig_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (b_if.record_trigger) begin
                trig_cnt++;
                if (trig_cyc == 0) trig_cyc = i;
            end
            step(1);
        end
        check_output("timeout_trig_count", 32'(trig_cnt), 32'd1);
        check_output("timeout_trig_cycle", 32'(trig_cyc == 16 || trig_cyc == 17), 32'd1);
        check_output("timeout_flag", {30'd0, b_if.timed_out, b_if.record_start}, 32'h3);
        b_if.record_end = 1'b1;
        step(1);
        b_if.record_end = 1'b0;
        check_output("timeout_rec_drop", 32'(b_if.record_start), 32'd0);
        b_if.cmd_valid = 1'b1;
        b_if.cmd_data  = 8'h53;
        step(1);
        b_if.cmd_valid = 1'b0;
        tries = 0;
        while (!b_if.tx_valid && tries < 10) begin
            step(1);
            tries++;
        end
        check_output("timeout_status", {23'd0, b_if.tx_valid, b_if.tx_data}, 32'h15C);
        step(1);
        check_output("timeout_idle", 32'(b_if.busy), 32'd0);

        // Framed dump of 40 bytes with a stuttering host.
        for (int i = 0; i < 40; i++) snoop_bytes[i] = 8'($urandom);
        snoop_idx = 0;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 40; i++) exp_q.push_back(snoop_bytes[i]);
        exp_q.push_back(8'h28);
        exp_q.push_back(8'h00);
        toggle_ready = 1'b1;
        apply_stimulus(8'h44);
        wait_drain(400);
        toggle_ready = 1'b0;
        step(2);
        check_output("dump_done", {29'd0, a_if.dump_start, a_if.busy, 1'b0}, 32'h0);
        check_output("snoop_taken", 32'(snoop_idx), 32'd40);
        exp_q.push_back(8'hEE);
        apply_stimulus(8'h44);
        wait_drain(20);

        // Abort while recording, then a stray trigger in IDLE.
        trig_before = trig_a;
        apply_stimulus(8'h52);
        apply_stimulus(8'h58);
        check_output("abort_idle", {30'd0, a_if.record_start, a_if.busy}, 32'h0);
        apply_stimulus(8'h54);
        step(10);
        check_output("abort_no_trig", 32'(trig_a - trig_before), 32'd0);
        check_output("abort_no_tx", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(8'h50);
        apply_stimulus(8'h53);
        wait_drain(20);

        // Synchronous reset in the middle of a capture.
        apply_stimulus(8'h52);
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_output("reset_mid_rec", {29'd0, a_if.record_start, a_if.busy, a_if.cmd_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
